// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_phy_pkg
// Brief    : Shared PHY scrambling helpers (24-bit LFSR step, keystream) and
//            skid-buffer state encoding, used by TX scrambler and RX descrambler.
// Revision : 1.0 - initial release
// ============================================================================
package pcie_phy_pkg;

    localparam int LFSR_WIDTH = 24;
    localparam int KS_WIDTH   = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // All-ones maps to itself; the RX side depends on this exact polynomial.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] lfsr);
        return {lfsr[22:0],
                lfsr[23] ^ lfsr[21] ^ lfsr[16] ^ lfsr[8] ^ lfsr[5] ^ lfsr[2] ^ 1'b1};
    endfunction

    function automatic logic [KS_WIDTH-1:0] keystream(input logic [LFSR_WIDTH-1:0] lfsr);
        return {lfsr, lfsr[23:16]};
    endfunction

endpackage : pcie_phy_pkg
`default_nettype wire

// File: rtl/pcie_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pcie_skid_buffer
// Brief    : Generic 2-entry valid/ready skid buffer; in_ready is a pure
//            decode of the state register (no combinational path from out_ready).
// Revision : 1.0 - initial release
// ============================================================================
module pcie_skid_buffer
    import pcie_phy_pkg::*;
#(
    parameter int WIDTH = 129
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      r_state;
    skid_state_t      w_state_next;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_load_out_in;
    logic             w_load_out_skid;
    logic             w_load_skid;

    assign in_ready  = (r_state != SKID_TWO);
    assign out_valid = (r_state != SKID_EMPTY);
    assign out_data  = r_out;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_state_next    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) begin
                    w_state_next  = SKID_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            SKID_ONE: begin
                // Accept and drain together: output register takes the new beat, no bubble.
                if (w_accept && out_ready) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    w_state_next = SKID_TWO;
                    w_load_skid  = 1'b1;
                end else if (out_ready) begin
                    w_state_next = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (out_ready) begin
                    w_state_next    = SKID_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out_in) begin
                r_out <= in_data;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule : pcie_skid_buffer
`default_nettype wire

// File: rtl/pcie_tx_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : pcie_tx_scrambler
// Brief    : TX beat scrambler: XORs the low 32 bits of data beats with the
//            24-bit LFSR keystream shared with the RX descrambler.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_tx_scrambler
    import pcie_phy_pkg::*;
#(
    parameter int                    DATA_WIDTH = 128,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scramble_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_is_os,
    input  logic                  in_reseed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_is_os
);

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [DATA_WIDTH-1:0] w_ks;
    logic [DATA_WIDTH-1:0] w_scr_data;
    logic [DATA_WIDTH:0]   w_skid_out;
    logic                  w_accept;

    assign w_accept = in_valid && in_ready;

    // Only the low KS_WIDTH bits are scrambled; upper bits pass through.
    always_comb begin
        w_ks = '0;
        if (scramble_en && !in_is_os) begin
            w_ks[KS_WIDTH-1:0] = keystream(r_lfsr);
        end
    end

    assign w_scr_data = in_data ^ w_ks;

    // Re-seed wins over the advance; the current beat already used the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            if (in_reseed) begin
                r_lfsr <= LFSR_SEED;
            end else if (!in_is_os) begin
                r_lfsr <= lfsr_next(r_lfsr);
            end
        end
    end

    pcie_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_is_os, w_scr_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_skid_out)
    );

    assign out_is_os = w_skid_out[DATA_WIDTH];
    assign out_data  = w_skid_out[DATA_WIDTH-1:0];

endmodule : pcie_tx_scrambler
`default_nettype wire

// File: doc/pcie_tx_scrambler.md
Name: pcie_tx_scrambler

Overview:
- TX-side counterpart of the PHY RX descrambler: XORs outgoing data beats with the same 24-bit LFSR keystream so the RX descrambler recovers the original data.
- Sits between the TX link-layer beat stream and the TX PHY serializer.
- Valid/ready handshake on both sides, through a 2-entry skid buffer.
- Supports ordered-set bypass, LFSR re-seed (EIEOS) and a global scramble disable for training.

Parameters:
- DATA_WIDTH, 128, beat width in bits; must be >= 32.
- LFSR_SEED, 24'hFFFFFF, LFSR value after reset or re-seed; must equal the RX descrambler seed.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- scramble_en  in  1  1 = scramble data beats; 0 = pass all beats unmodified (LFSR still advances)
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  DATA_WIDTH  upstream beat
- in_is_os  in  1  beat is an ordered set: never scrambled, LFSR not advanced
- in_reseed  in  1  reload LFSR with LFSR_SEED after this beat (qualified by in_valid and in_ready)
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  scrambled beat
- out_is_os  out  1  in_is_os forwarded with the beat

Behaviour:
- Reset:
  - lfsr = LFSR_SEED.
  - Skid buffer empty; out_valid = 0, out_data = 0, out_is_os = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- LFSR step:
  - next = {lfsr[22:0], lfsr[23]^lfsr[21]^lfsr[16]^lfsr[8]^lfsr[5]^lfsr[2]^1'b1}.
- Keystream for a beat:
  - ks = {(DATA_WIDTH-32)'b0, lfsr, lfsr[23:16]}, using the lfsr value current when the beat is accepted.
  - Only bits [31:0] are scrambled; upper bits pass unmodified. This matches the RX descrambler bit-for-bit.
- Accept:
  - A beat is accepted when in_valid && in_ready.
  - Data beat (in_is_os = 0): stored data = in_data ^ (scramble_en ? ks : 0); lfsr <= next.
  - OS beat (in_is_os = 1): stored data = in_data; lfsr unchanged.
  - in_reseed on an accepted beat: lfsr <= LFSR_SEED. This overrides the advance. The beat itself uses the pre-reseed lfsr.
  - in_reseed with no accept: ignored.
- Skid buffer, states EMPTY / ONE / TWO:
  - EMPTY: accept -> ONE.
  - ONE: accept with no out_ready -> TWO. out_ready with no accept -> EMPTY. Both -> ONE (stays full).
  - TWO: out_ready -> ONE (skid entry moves to the output register). No accept is possible.
- Handshake rules:
  - in_ready = registered (state != TWO); it does not depend combinationally on out_ready.
  - out_valid = (state != EMPTY). out_data and out_is_os come directly from the output register.
  - out_data and out_is_os are held stable while out_valid && !out_ready.
  - Latency: 1 cycle from accept to out_valid when the buffer is empty.
  - Throughput: 1 beat/cycle while out_ready = 1.
  - Ordering: strict FIFO.
- Boundary conditions:
  - Simultaneous accept and drain in ONE: the output register loads the new beat in the same cycle; no bubble.
  - scramble_en toggling mid-stream: takes effect on the next accepted beat. Beats already buffered keep the value computed at accept.
  - Async reset mid-operation: buffered beats are discarded and lfsr returns to LFSR_SEED.
  - All-ones is a fixed point of the step (next(24'hFFFFFF) = 24'hFFFFFF). This is intended and required for RX compatibility.

Decomposition:
- Package pcie_phy_pkg:
  - LFSR_WIDTH = 24.
  - KS_WIDTH = 32.
  - Function lfsr_next(lfsr) implementing the step.
  - Function keystream(lfsr).
  - Skid-state enum (EMPTY, ONE, TWO).
  - The RX descrambler is to be migrated to the same functions.
- Sub-module pcie_skid_buffer (generic 2-entry valid/ready buffer with payload = {is_os, data}), so the scrambler top holds only LFSR and XOR logic.

Test Plan:
- Default seed, out_ready = 1, four data beats of 0 -> out_data[31:0] = 32'hFFFFFFFF on every beat, upper 96 bits 0, out_valid exactly 1 cycle after each accept.
- LFSR_SEED = 24'h000001, data beats 0, 0 -> out_data[31:0] = 32'h00000100, then 32'h00000300.
- Same seed; sequence data, OS (in_data = 128'hA5...A5), data (all beats in_data = 0 except the OS beat) -> OS output exactly 128'hA5...A5; third beat out_data[31:0] = 32'h00000300 (LFSR not advanced by the OS beat).
- Same seed; beat 1 with in_reseed, then beat 2, both in_data = 0 -> beat 1 uses 32'h00000100; beat 2 uses 32'h00000100 again.
- Hold out_ready = 0 while sending 3 beats -> 2 accepted, in_ready = 0 on the cycle after the second accept, out_data stable; release out_ready -> beats emerge in order, third accepted, none lost or duplicated.
- scramble_en = 0, in_data = 128'h1234 -> out_data = 128'h1234 while the LFSR still advances: with scramble_en re-enabled on the next beat (seed 24'h000001, in_data = 0), out_data[31:0] = 32'h00000300. Then assert reset mid-stream -> out_valid = 0 and the next beat uses the seed keystream.
